// File: rtl/shift_reg_sipo_word.sv
// Serial-in/parallel-out word assembler: shifts sdi on en, latches Q with a one-cycle q_valid pulse.
// Optional even-parity trailer bit per frame when SHIFT_REG_SIPO_PARITY_EN is defined.
module shift_reg_sipo_word #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sdi,
    input  logic                         en,
    input  logic                         clear,
    output logic [WIDTH-1:0]             Q,
    output logic                         q_valid,
    output logic [WIDTH-1:0]             live,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
    output logic                         par_err
);

    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH-1);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign shifted = {shreg[WIDTH-2:0], sdi};
        end else begin : g_lsb
            assign shifted = {sdi, shreg[WIDTH-1:1]};
        end
    endgenerate

    assign live = shreg;

`ifdef SHIFT_REG_SIPO_PARITY_EN
    localparam logic [CW-1:0] PAR_SLOT = CW'(WIDTH);

    // The parity bit occupies slot WIDTH and is checked, never shifted in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            Q       <= '0;
            q_valid <= 1'b0;
            par_err <= 1'b0;
        end else begin
            q_valid <= 1'b0;
            if (clear) begin
                shreg   <= '0;
                bit_cnt <= '0;
                par_err <= 1'b0;
            end else if (en) begin
                if (bit_cnt == PAR_SLOT) begin
                    Q       <= shreg;
                    q_valid <= 1'b1;
                    par_err <= (^shreg) ^ sdi;
                    bit_cnt <= '0;
                end else begin
                    shreg   <= shifted;
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end
`else
    assign par_err = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            Q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= 1'b0;
            if (clear) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (en) begin
                shreg <= shifted;
                // Last bit goes straight into Q so the next frame can start with no dead cycle.
                if (bit_cnt == LAST_DATA) begin
                    Q       <= shifted;
                    q_valid <= 1'b1;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_shift_reg_sipo_word.sv
// Bench for shift_reg_sipo_word: three instances (4-bit MSB-first, 4-bit LSB-first, 8-bit MSB-first).
module tb_shift_reg_sipo_word;

    logic clk;
    logic rst;

    logic       a_sdi, a_en, a_clr;
    logic [3:0] a_q, a_live;
    logic [2:0] a_cnt;
    logic       a_qv, a_pe;

    logic       b_sdi, b_en, b_clr;
    logic [3:0] b_q, b_live;
    logic [2:0] b_cnt;
    logic       b_qv, b_pe;

    logic       c_sdi, c_en, c_clr;
    logic [7:0] c_q, c_live;
    logic [3:0] c_cnt;
    logic       c_qv, c_pe;

    int total = 0;
    int bad   = 0;

    logic [3:0] qa[$];
    logic [3:0] qb[$];
    logic [7:0] qc[$];

    shift_reg_sipo_word #(.WIDTH(4), .MSB_FIRST(1)) u_a (
        .clk(clk), .reset(rst), .sdi(a_sdi), .en(a_en), .clear(a_clr),
        .Q(a_q), .q_valid(a_qv), .live(a_live), .bit_cnt(a_cnt), .par_err(a_pe));

    shift_reg_sipo_word #(.WIDTH(4), .MSB_FIRST(0)) u_b (
        .clk(clk), .reset(rst), .sdi(b_sdi), .en(b_en), .clear(b_clr),
        .Q(b_q), .q_valid(b_qv), .live(b_live), .bit_cnt(b_cnt), .par_err(b_pe));

    shift_reg_sipo_word #(.WIDTH(8), .MSB_FIRST(1)) u_c (
        .clk(clk), .reset(rst), .sdi(c_sdi), .en(c_en), .clear(c_clr),
        .Q(c_q), .q_valid(c_qv), .live(c_live), .bit_cnt(c_cnt), .par_err(c_pe));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; returns at the next falling edge with outputs settled.
    task automatic a_bit(input logic b);
        a_en = 1'b1; a_sdi = b;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_sdi = 0; a_en = 0; a_clr = 0;
        b_sdi = 0; b_en = 0; b_clr = 0;
        c_sdi = 0; c_en = 0; c_clr = 0;
        #2 rst = 1'b0;
        #1;
        total++;
        if ({a_q, a_qv, a_live, a_cnt, a_pe} !== 13'd0) begin
            bad++; $display("FAIL reset_a got=%h want=0", {a_q, a_qv, a_live, a_cnt, a_pe});
        end
        total++;
        if ({b_q, b_qv, b_live, b_cnt, b_pe, c_q, c_qv, c_live, c_cnt, c_pe} !== 35'd0) begin
            bad++; $display("FAIL reset_bc got=%h want=0",
                            {b_q, b_qv, b_live, b_cnt, b_pe, c_q, c_qv, c_live, c_cnt, c_pe});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

`ifndef SHIFT_REG_SIPO_PARITY_EN
    task automatic test_msb_frame();
        logic [3:0] exp;
        qa.push_back(4'hC);
        a_bit(1); a_bit(1); a_bit(0);
        total++;
        if (a_qv !== 1'b0 || a_cnt !== 3'd3) begin
            bad++; $display("FAIL msb_partial qv=%b cnt=%0d want qv=0 cnt=3", a_qv, a_cnt);
        end
        a_bit(0);
        a_en = 1'b0;
        total++;
        if (a_qv !== 1'b1) begin bad++; $display("FAIL msb_qv got=%b want=1", a_qv); end
        exp = qa.pop_front();
        total++;
        if (a_q !== exp) begin bad++; $display("FAIL msb_q got=%h want=%h", a_q, exp); end
        total++;
        if (a_cnt !== 3'd0) begin bad++; $display("FAIL msb_cnt got=%0d want=0", a_cnt); end
        @(negedge clk);
        total++;
        if (a_qv !== 1'b0 || a_q !== 4'hC) begin
            bad++; $display("FAIL msb_pulse_width qv=%b q=%h want qv=0 q=c", a_qv, a_q);
        end
    endtask

    task automatic test_lsb_back_to_back();
        logic [7:0] pat;
        logic [3:0] exp;
        logic       exp_v;
        pat = 8'b1100_1010;
        qb.push_back(4'h3);
        qb.push_back(4'h5);
        for (int i = 0; i < 8; i++) begin
            b_en = 1'b1; b_sdi = pat[7-i];
            @(negedge clk);
            exp_v = (i % 4 == 3);
            total++;
            if (b_qv !== exp_v) begin
                bad++; $display("FAIL lsb_qv bit=%0d got=%b want=%b", i, b_qv, exp_v);
            end
            if (exp_v) begin
                exp = qb.pop_front();
                total++;
                if (b_q !== exp) begin bad++; $display("FAIL lsb_q got=%h want=%h", b_q, exp); end
            end
        end
        b_en = 1'b0;
    endtask

    task automatic test_gaps();
        logic [7:0] w;
        logic [7:0] part;
        logic [7:0] exp;
        w = 8'hA5;
        part = 8'h00;
        qc.push_back(w);
        for (int i = 0; i < 8; i++) begin
            c_en = 1'b1; c_sdi = w[7-i];
            @(negedge clk);
            c_en = 1'b0;
            part = {part[6:0], w[7-i]};
            total++;
            if (c_live !== part) begin
                bad++; $display("FAIL gap_live bit=%0d got=%h want=%h", i, c_live, part);
            end
            if (i < 7) begin
                total++;
                if (c_qv !== 1'b0 || c_cnt !== 4'(i+1)) begin
                    bad++; $display("FAIL gap_partial bit=%0d qv=%b cnt=%0d want qv=0 cnt=%0d",
                                    i, c_qv, c_cnt, i+1);
                end
            end else begin
                exp = qc.pop_front();
                total++;
                if (c_qv !== 1'b1 || c_q !== exp) begin
                    bad++; $display("FAIL gap_word qv=%b q=%h want qv=1 q=%h", c_qv, c_q, exp);
                end
            end
            for (int g = 0; g < 3; g++) begin
                @(negedge clk);
                total++;
                if (c_qv !== 1'b0 || c_live !== part) begin
                    bad++; $display("FAIL gap_hold bit=%0d qv=%b live=%h want qv=0 live=%h",
                                    i, c_qv, c_live, part);
                end
            end
        end
    endtask

    task automatic test_clear();
        logic [3:0] exp;
        a_bit(1); a_bit(0);
        a_clr = 1'b1; a_en = 1'b1; a_sdi = 1'b1;
        @(negedge clk);
        a_clr = 1'b0; a_en = 1'b0;
        total++;
        if (a_cnt !== 3'd0 || a_live !== 4'h0 || a_qv !== 1'b0 || a_q !== 4'hC) begin
            bad++; $display("FAIL clear cnt=%0d live=%h qv=%b q=%h want 0 0 0 c",
                            a_cnt, a_live, a_qv, a_q);
        end
        qa.push_back(4'h9);
        a_bit(1); a_bit(0); a_bit(0);
        total++;
        if (a_q !== 4'hC || a_qv !== 1'b0) begin
            bad++; $display("FAIL clear_q_hold q=%h qv=%b want q=c qv=0", a_q, a_qv);
        end
        a_bit(1);
        a_en = 1'b0;
        exp = qa.pop_front();
        total++;
        if (a_qv !== 1'b1 || a_q !== exp) begin
            bad++; $display("FAIL clear_word qv=%b q=%h want qv=1 q=%h", a_qv, a_q, exp);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] exp;
        a_bit(1); a_bit(1);
        a_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        total++;
        if ({a_q, a_qv, a_live, a_cnt} !== 12'd0) begin
            bad++; $display("FAIL midreset got=%h want=0", {a_q, a_qv, a_live, a_cnt});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        qa.push_back(4'hC);
        a_bit(1); a_bit(1); a_bit(0); a_bit(0);
        a_en = 1'b0;
        exp = qa.pop_front();
        total++;
        if (a_qv !== 1'b1 || a_q !== exp) begin
            bad++; $display("FAIL after_reset_word qv=%b q=%h want qv=1 q=%h", a_qv, a_q, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] w [3];
        logic [3:0] exp;
        for (int k = 0; k < 3; k++) begin
            w[k] = 4'($urandom_range(0, 15));
            qa.push_back(w[k]);
        end
        for (int i = 0; i < 12; i++) begin
            a_en = 1'b1; a_sdi = w[i/4][3 - (i % 4)];
            @(negedge clk);
            total++;
            if (a_qv !== (i % 4 == 3)) begin
                bad++; $display("FAIL b2b_qv bit=%0d got=%b", i, a_qv);
            end
            if (a_qv) begin
                exp = qa.pop_front();
                total++;
                if (a_q !== exp) begin bad++; $display("FAIL b2b_q got=%h want=%h", a_q, exp); end
            end
        end
        a_en = 1'b0;
    endtask
`else
    task automatic test_parity();
        logic [3:0] exp;
        qa.push_back(4'hB);
        a_bit(1); a_bit(0); a_bit(1); a_bit(1);
        total++;
        if (a_cnt !== 3'd4 || a_qv !== 1'b0) begin
            bad++; $display("FAIL par_cnt cnt=%0d qv=%b want cnt=4 qv=0", a_cnt, a_qv);
        end
        a_bit(1);
        a_en = 1'b0;
        exp = qa.pop_front();
        total++;
        if (a_qv !== 1'b1 || a_q !== exp || a_pe !== 1'b0) begin
            bad++; $display("FAIL par_good qv=%b q=%h pe=%b want 1 %h 0", a_qv, a_q, a_pe, exp);
        end
        qa.push_back(4'hB);
        a_bit(1); a_bit(0); a_bit(1); a_bit(1); a_bit(0);
        a_en = 1'b0;
        exp = qa.pop_front();
        total++;
        if (a_qv !== 1'b1 || a_q !== exp || a_pe !== 1'b1) begin
            bad++; $display("FAIL par_bad qv=%b q=%h pe=%b want 1 %h 1", a_qv, a_q, a_pe, exp);
        end
        a_bit(0);
        a_en = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (a_pe !== 1'b1) begin bad++; $display("FAIL par_hold got=%b want=1", a_pe); end
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        total++;
        if (a_pe !== 1'b0 || a_cnt !== 3'd0) begin
            bad++; $display("FAIL par_clear pe=%b cnt=%0d want 0 0", a_pe, a_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifndef SHIFT_REG_SIPO_PARITY_EN
        test_msb_frame();
        test_lsb_back_to_back();
        test_gaps();
        test_clear();
        test_reset_mid_frame();
        test_back_to_back();
`else
        test_parity();
`endif
        total++;
        if (qa.size() + qb.size() + qc.size() != 0) begin
            bad++; $display("FAIL leftover_expected got=%0d want=0", qa.size() + qb.size() + qc.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
